// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-side responder.
// Used by mem_array and mem_responder.
package mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Even-parity bit of a word zero-extended to 64 bits.
  function automatic logic even_par(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port storage: synchronous write, synchronous registered read.
// With MEM_PARITY_EN each word carries an extra even-parity bit, checked on read.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
  output logic              rd_perr,
`endif
  output logic [DATA_W-1:0] rdata
);

`ifdef MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem_r [2**ADDR_W];
  logic [WORD_W-1:0] wword_s;
  logic [WORD_W-1:0] rword_s;
  logic [DATA_W-1:0] rdata_r;

`ifdef MEM_PARITY_EN
  logic perr_r;
  assign wword_s = {even_par(64'(wdata)), wdata};
`else
  assign wword_s = wdata;
`endif
  assign rword_s = mem_r[addr];

  // Storage write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wword_s;
    end
  end

  // Registered read data, held until the next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= rword_s[DATA_W-1:0];
    end
  end

`ifdef MEM_PARITY_EN
  // Parity check over data plus stored parity bit: any odd count is an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_r <= 1'b0;
    end else if (re) begin
      perr_r <= even_par(64'(rword_s));
    end
  end
  assign rd_perr = perr_r;
`endif

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: MAR register, wait-state FSM and flags around mem_array.
// Optional MEM_PARITY_EN adds a stored parity bit and the parity_err output.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              MEM_clk,
  input  logic              MEM_rst_n,
  input  logic              MAR_we,
  input  logic              MBR_we,
  input  logic              RAM_we,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              busy,
  output logic              ovf,
`ifdef MEM_PARITY_EN
  output logic              parity_err,
`endif
  input  logic              ovf_clr
);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:0] mar_r;
  logic [DATA_W-1:0] wdata_r;
  logic              op_wr_r;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic              ovf_r, ovf_s;
  logic              req_s, strobe_s, acc_s;

  assign req_s    = MBR_we | RAM_we;
  assign strobe_s = MAR_we | req_s;
  assign acc_s    = (state_r == WAIT) && (cnt_r == CNT_W'(0));

  // State register
  always_ff @(posedge MEM_clk or negedge MEM_rst_n) begin
    if (!MEM_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = req_s ? WAIT : IDLE;
      WAIT:    state_s = acc_s ? DONE : WAIT;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the registered flags; a new overflow beats ovf_clr
  always_comb begin
    ready_s = (state_s == DONE);
    busy_s  = (state_s != IDLE);
    if ((state_r != IDLE) && strobe_s) begin
      ovf_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // Registered flags
  always_ff @(posedge MEM_clk or negedge MEM_rst_n) begin
    if (!MEM_rst_n) begin
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      ready_r <= ready_s;
      busy_r  <= busy_s;
      ovf_r   <= ovf_s;
    end
  end

  // MAR, request capture and wait counter; strobes outside IDLE never touch them
  always_ff @(posedge MEM_clk or negedge MEM_rst_n) begin
    if (!MEM_rst_n) begin
      mar_r   <= '0;
      cnt_r   <= '0;
      wdata_r <= '0;
      op_wr_r <= 1'b0;
    end else if (state_r == IDLE) begin
      if (MAR_we) begin
        mar_r <= addr_in;
      end
      if (req_s) begin
        op_wr_r <= RAM_we;
        wdata_r <= data_in;
        cnt_r   <= CNT_W'(WAIT_CYCLES);
      end
    end else if ((state_r == WAIT) && !acc_s) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (MEM_clk),
    .rst_n   (MEM_rst_n),
    .we      (acc_s & op_wr_r),
    .re      (acc_s & ~op_wr_r),
    .addr    (mar_r),
    .wdata   (wdata_r),
`ifdef MEM_PARITY_EN
    .rd_perr (parity_err),
`endif
    .rdata   (data_out)
  );

  assign ready = ready_r;
  assign busy  = busy_r;
  assign ovf   = ovf_r;

endmodule
